// File: rtl/i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_rx
//  Brief    : Write-only I2C slave receiver with a first-word fall-through
//             byte FIFO, fed from oversampled SCL/SDA.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h10,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       core_clk,
    input  logic       core_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [4:0] rx_level,
    output logic       busy,
    output logic       addr_hit,
    output logic       overflow
);

    localparam int                 c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]         c_DEPTH   = 5'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    // Synchronizers reset to 1 so a reset looks like an idle bus.
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    state_t             r_state;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_sda_oe;
    logic               r_busy;
    logic               r_addr_hit;
    logic               r_overflow;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [4:0]         r_level;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_byte_done, w_full, w_addr_match, w_push, w_pop;

    assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte_done  = w_scl_fall & (r_bit_cnt == 4'd8);
    assign w_full       = (r_level == c_DEPTH);
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR) & ~r_shift[0];
    assign w_push       = (r_state == S_DATA) & w_byte_done & ~w_full;
    assign w_pop        = rx_valid & rx_ready;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_addr_hit <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_addr_hit <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_DATA: begin
                        if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                            r_shift   <= {r_shift[6:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == S_ADDR) begin
                                if (w_addr_match) begin
                                    r_addr_hit <= 1'b1;
                                    r_sda_oe   <= 1'b1;
                                    r_state    <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else if (!w_full) begin
                                r_sda_oe <= 1'b1;
                                r_state  <= S_DATA_ACK;
                            end else begin
                                // Byte lost: NACK and stay off the bus until the next condition.
                                r_overflow <= 1'b1;
                                r_state    <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_DATA;
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_mem[r_rd_ptr];
    assign rx_valid = (r_level != 5'd0);
    assign rx_level = r_level;
    assign busy     = r_busy;
    assign addr_hit = r_addr_hit;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_rx
//  Brief    : Bit-banged I2C master driving i2c_slave_rx, with a byte-queue
//             reference model and a popping consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx;

    localparam int PH    = 5;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       core_rst;
    logic       scl;
    logic       sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] rx_level;
    logic       busy;
    logic       addr_hit;
    logic       overflow;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (7'h10),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .core_clk (clk),
        .core_rst (core_rst),
        .scl_i    (scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_level (rx_level),
        .busy     (busy),
        .addr_hit (addr_hit),
        .overflow (overflow)
    );

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         hit_cnt    = 0;
    int         coinc_cnt  = 0;
    int         ready_mode = 0;   // 0 hold off, 1 always pop, 2 random
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] addr;
        int         nbytes;
        logic [7:0] first;
        logic       exp_ack;
        int         exp_hits;
        int         exp_level;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Consumer: pops against the model queue and watches FIFO invariants.
    logic       prev_valid = 1'b0;
    logic       prev_pop   = 1'b0;
    logic       prev_rst   = 1'b1;
    logic [7:0] prev_data  = 8'd0;
    int         prev_level = 0;

    always @(negedge clk) begin
        logic       r;
        int         delta;
        logic [7:0] eb;
        if (addr_hit) hit_cnt++;
        if (core_rst)             r = 1'b0;
        else if (ready_mode == 1) r = 1'b1;
        else if (ready_mode == 2) r = 1'($urandom_range(0, 1));
        else                      r = 1'b0;
        if (!prev_rst && !core_rst) begin
            delta = int'(rx_level) - prev_level;
            if (prev_pop && delta == 0) coinc_cnt++;
            if (!(delta == -int'(prev_pop) || delta == 1 - int'(prev_pop))) begin
                n_fail++;
                $display("FAIL level_step: level %0d after %0d with pop=%0d", rx_level, prev_level, prev_pop);
            end
            if (prev_valid && !prev_pop && rx_valid && rx_data !== prev_data) begin
                n_fail++;
                $display("FAIL head_stable: rx_data %0h changed from %0h without a pop", rx_data, prev_data);
            end
        end
        if (rx_valid && r) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: got %0h, expected no byte (model empty)", rx_data);
            end else begin
                eb = exp_q.pop_front();
                if (rx_data !== eb) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h, expected %0h", rx_data, eb);
                end
            end
        end
        prev_valid = rx_valid;
        prev_pop   = rx_valid & r;
        prev_data  = rx_data;
        prev_level = int'(rx_level);
        prev_rst   = core_rst;
        rx_ready   = r;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic v, output logic oe_hi);
        sda_drv = v;
        wait_clks(PH);
        scl = 1'b1;
        wait_clks(PH);
        oe_hi = sda_oe;
        scl = 1'b0;
        wait_clks(PH);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(PH);
        scl     = 1'b1; wait_clks(PH);
        sda_drv = 1'b0; wait_clks(PH);
        scl     = 1'b0; wait_clks(PH);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(PH);
        scl     = 1'b1; wait_clks(PH);
        sda_drv = 1'b1; wait_clks(PH);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic model_push,
                             output logic ack, output logic oe_bits);
        logic o;
        oe_bits = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && model_push) exp_q.push_back(b);
            bit_cycle(b[i], o);
            oe_bits |= o;
        end
        bit_cycle(1'b1, ack);
    endtask

    task automatic drain();
        int t;
        t = 0;
        ready_mode = 1;
        while ((rx_valid || exp_q.size() != 0) && t < 100) begin
            wait_clks(1);
            t++;
        end
        ready_mode = 0;
        wait_clks(2);
        check("drain_level", rx_level, 0);
        check("drain_model_empty", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       vt[5];
        logic       a, ob, o, ack_or, ob_or, match;
        int         h0, c0, nb, sel;
        logic [7:0] ad, d, b;

        vt[0] = '{8'h20, 1, 8'h01, 1'b1, 1, 1};
        vt[1] = '{8'h22, 2, 8'h33, 1'b0, 0, 0};
        vt[2] = '{8'h21, 1, 8'h55, 1'b0, 0, 0};
        vt[3] = '{8'h20, 3, 8'hA5, 1'b1, 1, 3};
        vt[4] = '{8'h00, 1, 8'h11, 1'b0, 0, 0};

        core_rst = 1'b1;
        scl      = 1'b1;
        sda_drv  = 1'b1;
        wait_clks(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_level", rx_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr_hit", addr_hit, 0);
        core_rst = 1'b0;
        wait_clks(5);

        // Table-driven single transactions.
        for (int k = 0; k < 5; k++) begin
            ready_mode = 0;
            h0 = hit_cnt;
            i2c_start();
            check($sformatf("v%0d_busy_start", k), busy, 1);
            send_byte(vt[k].addr, 1'b0, a, ob);
            check($sformatf("v%0d_addr_ack", k), a, vt[k].exp_ack);
            ack_or = 1'b0;
            ob_or  = ob;
            for (int j = 0; j < vt[k].nbytes; j++) begin
                send_byte(vt[k].first + 8'(j), vt[k].exp_ack, a, ob);
                ob_or |= ob;
                if (vt[k].exp_ack) check($sformatf("v%0d_data_ack%0d", k, j), a, 1);
                else ack_or |= a;
            end
            i2c_stop();
            check($sformatf("v%0d_busy_stop", k), busy, 0);
            check($sformatf("v%0d_oe_in_bits", k), ob_or, 0);
            if (!vt[k].exp_ack) check($sformatf("v%0d_no_ack", k), ack_or, 0);
            check($sformatf("v%0d_hits", k), hit_cnt - h0, vt[k].exp_hits);
            check($sformatf("v%0d_level", k), rx_level, vt[k].exp_level);
            if (vt[k].exp_level > 0) check($sformatf("v%0d_head", k), rx_data, vt[k].first);
            drain();
        end

        // Continuous pops while pushing 0x02..0x08.
        ready_mode = 1;
        i2c_start();
        send_byte(8'h20, 1'b0, a, ob);
        check("cont_addr_ack", a, 1);
        for (int j = 2; j <= 8; j++) begin
            send_byte(8'(j), 1'b1, a, ob);
            check($sformatf("cont_ack_%0d", j), a, 1);
        end
        i2c_stop();
        drain();

        // Pop window straddling the push of the last byte.
        ready_mode = 0;
        i2c_start();
        send_byte(8'h20, 1'b0, a, ob);
        for (int j = 2; j <= 7; j++) send_byte(8'(j), 1'b1, a, ob);
        check("coinc_prefill_level", rx_level, 6);
        b = 8'h08;
        for (int i = 7; i >= 1; i--) bit_cycle(b[i], o);
        exp_q.push_back(b);
        sda_drv = b[0];
        wait_clks(PH);
        scl = 1'b1;
        wait_clks(PH);
        c0 = coinc_cnt;
        scl = 1'b0;
        ready_mode = 1;
        wait_clks(PH);
        ready_mode = 0;
        bit_cycle(1'b1, a);
        check("coinc_ack", a, 1);
        check("coinc_push_pop_same_cycle", coinc_cnt > c0, 1);
        i2c_stop();
        drain();

        // Overflow: nine bytes into an eight-deep FIFO with no pops.
        ready_mode = 0;
        i2c_start();
        send_byte(8'h20, 1'b0, a, ob);
        check("ovf_addr_ack", a, 1);
        for (int j = 1; j <= 9; j++) begin
            send_byte(8'(j), exp_q.size() < DEPTH, a, ob);
            check($sformatf("ovf_ack_%0d", j), a, j <= 8);
        end
        check("ovf_flag", overflow, 1);
        check("ovf_level", rx_level, 8);
        i2c_stop();
        check("ovf_head", rx_data, 8'h01);
        drain();
        check("ovf_sticky", overflow, 1);

        // Reset pulsed during the 4th data bit.
        h0 = hit_cnt;
        i2c_start();
        send_byte(8'h20, 1'b0, a, ob);
        check("rst_mid_addr_ack", a, 1);
        b = 8'hA5;
        for (int i = 7; i >= 5; i--) bit_cycle(b[i], o);
        sda_drv = b[4];
        wait_clks(2);
        core_rst = 1'b1;
        wait_clks(1);
        check("rst_mid_outputs", {sda_oe, busy, addr_hit, overflow, rx_valid, rx_level}, 0);
        core_rst = 1'b0;
        wait_clks(PH - 3);
        scl = 1'b1;
        wait_clks(PH);
        ob_or = sda_oe;
        scl = 1'b0;
        wait_clks(PH);
        for (int i = 3; i >= 0; i--) begin
            bit_cycle(b[i], o);
            ob_or |= o;
        end
        bit_cycle(1'b1, a);
        ob_or |= a;
        send_byte(8'h20, 1'b0, a, ob);
        ob_or |= a | ob;
        check("rst_mid_no_ack", ob_or, 0);
        check("rst_mid_level", rx_level, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'h20, 1'b0, a, ob);
        check("rst_mid_new_addr_ack", a, 1);
        send_byte(8'h5A, 1'b1, a, ob);
        check("rst_mid_new_data_ack", a, 1);
        i2c_stop();
        check("rst_mid_hits", hit_cnt - h0, 2);
        check("rst_mid_overflow", overflow, 0);
        drain();

        // Random transactions: address rule, random pops, aborts, repeated STARTs.
        for (int t = 0; t < 14; t++) begin
            ready_mode = 2;
            sel = $urandom_range(0, 3);
            if (sel < 2)       ad = 8'h20;
            else if (sel == 2) ad = 8'h21;
            else               ad = 8'($urandom_range(0, 255));
            match = (ad[7:1] == 7'h10) && (ad[0] == 1'b0);
            nb = $urandom_range(0, 6);
            h0 = hit_cnt;
            i2c_start();
            send_byte(ad, 1'b0, a, ob);
            check($sformatf("rnd%0d_addr_ack_%0h", t, ad), a, match);
            for (int j = 0; j < nb; j++) begin
                d = 8'($urandom_range(0, 255));
                send_byte(d, match, a, ob);
                check($sformatf("rnd%0d_data_ack%0d", t, j), a, match);
            end
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(1, 7);
                for (int j = 0; j < sel; j++) bit_cycle(1'($urandom_range(0, 1)), o);
            end
            if (t == 13 || $urandom_range(0, 1) == 1) i2c_stop();
            check($sformatf("rnd%0d_hits", t), hit_cnt - h0, int'(match));
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
